apb_req_master: RTL and testbench

//  Request-to-APB4 master bridge; drives the Master modport of the team's APB interface.

---
 rtl/apb_req_master.sv | 197 +++++++++++++++++++
 tb/tb_apb_req_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_master.sv
// ---------------------------------------------------------------------------
// apb_req_master
//   Request-to-APB4 master bridge. Takes one transfer on a valid/ready
//   request channel, runs the APB SETUP and ACCESS phases, then returns the
//   read data and error status on a valid/ready response channel. Only one
//   transfer is outstanding at a time, and transfers are not pipelined.
//
// Build option
//   APB_MST_TIMEOUT_EN : when defined, an ACCESS phase aborts with an error
//                        after TIMEOUT_CYCLES cycles without pready_i. When
//                        undefined, ACCESS waits on pready_i indefinitely.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), async active-low reset
//   req_valid_i/ready_o  request handshake
//   req_addr_i           transfer address
//   req_write_i          1 = write, 0 = read
//   req_wdata_i          write data
//   req_strb_i           write byte strobes
//   req_prot_i           APB protection bits
//   rsp_valid_o/ready_i  response handshake
//   rsp_rdata_o          read data (0 for writes and timeouts)
//   rsp_err_o            pslverr_i of the transfer, or 1 on timeout
//   paddr_o .. pstrb_o   APB master outputs
//   pready_i, prdata_i,
//   pslverr_i            APB master inputs (sampled only in ACCESS)
// ---------------------------------------------------------------------------
module apb_req_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    localparam int unsigned STRB_WIDTH    = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [STRB_WIDTH-1:0] req_strb_i,
    input  logic [2:0]            req_prot_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,

    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [2:0]            pprot_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic [STRB_WIDTH-1:0] pstrb_o,
    input  logic                  pready_i,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pslverr_i
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_req_master: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t state, state_next;
    logic   accept;
    logic   complete;
    logic   abort;

`ifdef APB_MST_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and transfer events
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid_i) begin
                    accept     = 1'b1;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready_i takes priority over a timeout in the same cycle
                if (pready_i) begin
                    complete   = 1'b1;
                    state_next = ST_RESP;
                end
`ifdef APB_MST_TIMEOUT_EN
                else if (tmo_cnt == CNT_LIMIT) begin
                    abort      = 1'b1;
                    state_next = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Handshake and phase outputs decode from state alone, so reset
    // removes psel/penable immediately.
    assign req_ready_o = (state == ST_IDLE);
    assign psel_o      = (state == ST_SETUP) || (state == ST_ACCESS);
    assign penable_o   = (state == ST_ACCESS);
    assign rsp_valid_o = (state == ST_RESP);

    // ------------------------------------------------------------------
    // APB request registers: loaded on accept and held until the next
    // accept, so they stay quiet in IDLE and RESP.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            paddr_o  <= '0;
            pprot_o  <= '0;
            pwrite_o <= 1'b0;
            pwdata_o <= '0;
            pstrb_o  <= '0;
        end else if (accept) begin
            paddr_o  <= req_addr_i;
            pprot_o  <= req_prot_i;
            pwrite_o <= req_write_i;
            // Reads drive zero data and zero strobes
            pwdata_o <= req_write_i ? req_wdata_i : '0;
            pstrb_o  <= req_write_i ? req_strb_i  : '0;
        end
    end

    // ------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else if (complete) begin
            rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
            rsp_err_o   <= pslverr_i;
        end else if (abort) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b1;
        end
    end

`ifdef APB_MST_TIMEOUT_EN
    // ------------------------------------------------------------------
    // ACCESS wait counter: cleared in SETUP, counts ACCESS cycles that
    // end without pready_i.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt <= '0;
        end else if (state == ST_SETUP) begin
            tmo_cnt <= '0;
        end else if ((state == ST_ACCESS) && !pready_i && !abort) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_apb_req_master.sv
module tb_apb_req_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int errors = 0;
    int checks = 0;

    apb_req_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_addr_i (req_addr),
        .req_write_i(req_write),
        .req_wdata_i(req_wdata),
        .req_strb_i (req_strb),
        .req_prot_i (req_prot),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o  (rsp_err),
        .paddr_o    (paddr),
        .pprot_o    (pprot),
        .psel_o     (psel),
        .penable_o  (penable),
        .pwrite_o   (pwrite),
        .pwdata_o   (pwdata),
        .pstrb_o    (pstrb),
        .pready_i   (pready),
        .prdata_i   (prdata),
        .pslverr_i  (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; returns 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] p);
        req_addr  = a;
        req_write = w;
        req_wdata = d;
        req_strb  = s;
        req_prot  = p;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;
        set_req(32'h0, 1'b0, 32'h0, 4'h0, 3'h0);
        step();
        step();

        // ---------------- reset state
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_psel",      32'(psel),      32'h0);
        chk("rst_penable",   32'(penable),   32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_paddr",     paddr,          32'h0);
        chk("rst_rdata",     rsp_rdata,      32'h0);
        rst_n = 1'b1;
        step();

        // ---------------- 1: write, pready at first ACCESS
        pready = 1'b1;
        prdata = 32'h5555_AAAA;
        set_req(32'h1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'h2);
        req_valid = 1'b1;
        step();                                   // accept (T)
        req_valid = 1'b0;
        chk("t1_setup_psel",    32'(psel),      32'h1);
        chk("t1_setup_penable", 32'(penable),   32'h0);
        chk("t1_paddr",         paddr,          32'h1000);
        chk("t1_pwrite",        32'(pwrite),    32'h1);
        chk("t1_pwdata",        pwdata,         32'hDEAD_BEEF);
        chk("t1_pstrb",         32'(pstrb),     32'hF);
        chk("t1_pprot",         32'(pprot),     32'h2);
        chk("t1_req_ready",     32'(req_ready), 32'h0);
        step();                                   // T+1 -> ACCESS
        chk("t1_access_penable", 32'(penable),   32'h1);
        chk("t1_access_psel",    32'(psel),      32'h1);
        chk("t1_access_rspv",    32'(rsp_valid), 32'h0);
        step();                                   // T+2 pready sampled
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_err",   32'(rsp_err),   32'h0);
        chk("t1_rsp_rdata", rsp_rdata,      32'h0);
        chk("t1_resp_psel", 32'(psel),      32'h0);
        chk("t1_resp_pen",  32'(penable),   32'h0);
        chk("t1_resp_paddr_hold", paddr,    32'h1000);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("t1_idle_rspv",  32'(rsp_valid), 32'h0);
        chk("t1_idle_ready", 32'(req_ready), 32'h1);

        // ---------------- 2: read, 3 wait cycles
        pready = 1'b0;
        prdata = 32'h1111_1111;
        set_req(32'h2004, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'h0);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("t2_pwrite", 32'(pwrite), 32'h0);
        chk("t2_pstrb",  32'(pstrb),  32'h0);
        chk("t2_pwdata", pwdata,      32'h0);
        step();                                   // ACCESS
        for (int i = 0; i < 3; i++) begin
            chk("t2_wait_penable", 32'(penable),   32'h1);
            chk("t2_wait_psel",    32'(psel),      32'h1);
            chk("t2_wait_paddr",   paddr,          32'h2004);
            chk("t2_wait_pstrb",   32'(pstrb),     32'h0);
            chk("t2_wait_rspv",    32'(rsp_valid), 32'h0);
            step();
        end
        chk("t2_still_access", 32'(penable), 32'h1);
        pready = 1'b1;
        prdata = 32'hA5A5_0001;
        step();
        pready = 1'b0;
        prdata = 32'h0;
        chk("t2_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t2_rsp_rdata", rsp_rdata,      32'hA5A5_0001);
        chk("t2_rsp_err",   32'(rsp_err),   32'h0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // ---------------- 3: read with pslverr, response back-pressure
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'h1234_5678;
        set_req(32'h0300, 1'b0, 32'h0, 4'h0, 3'h1);
        req_valid = 1'b1;
        step();
        step();
        step();
        pslverr = 1'b0;
        prdata  = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_rspv",  32'(rsp_valid), 32'h1);
            chk("t3_hold_err",   32'(rsp_err),   32'h1);
            chk("t3_hold_rdata", rsp_rdata,      32'h1234_5678);
            chk("t3_hold_ready", 32'(req_ready), 32'h0);
            chk("t3_hold_psel",  32'(psel),      32'h0);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("t3_done_rspv", 32'(rsp_valid), 32'h0);
        chk("t3_done_psel", 32'(psel),      32'h0);

        // ---------------- 4: back-to-back with req_valid held high
        rsp_ready = 1'b1;
        pready    = 1'b1;
        prdata    = 32'hC0DE_0004;
        set_req(32'h4000, 1'b1, 32'h0000_00AA, 4'h1, 3'h0);
        req_valid = 1'b1;
        step();                                   // accept A
        set_req(32'h4010, 1'b0, 32'h0, 4'h0, 3'h0);
        chk("t4_a_paddr", paddr,          32'h4000);
        chk("t4_a_pstrb", 32'(pstrb),     32'h1);
        step();                                   // ACCESS A
        chk("t4_a_access_ready", 32'(req_ready), 32'h0);
        step();                                   // RESP A
        chk("t4_a_rspv",  32'(rsp_valid), 32'h1);
        chk("t4_a_ready", 32'(req_ready), 32'h0);
        chk("t4_a_rdata", rsp_rdata,      32'h0);
        step();                                   // IDLE gap
        chk("t4_gap_psel",  32'(psel),      32'h0);
        chk("t4_gap_ready", 32'(req_ready), 32'h1);
        chk("t4_gap_paddr", paddr,          32'h4000);
        step();                                   // accept B
        req_valid = 1'b0;
        chk("t4_b_psel",  32'(psel), 32'h1);
        chk("t4_b_paddr", paddr,     32'h4010);
        step();
        step();
        chk("t4_b_rspv",  32'(rsp_valid), 32'h1);
        chk("t4_b_rdata", rsp_rdata,      32'hC0DE_0004);
        step();
        rsp_ready = 1'b0;

        // ---------------- 5: reset during ACCESS
        pready = 1'b0;
        set_req(32'h5000, 1'b1, 32'h1234_0000, 4'hC, 3'h0);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("t5_pre_penable", 32'(penable), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_psel",    32'(psel),      32'h0);
        chk("t5_async_penable", 32'(penable),   32'h0);
        chk("t5_async_rspv",    32'(rsp_valid), 32'h0);
        step();
        chk("t5_rst_paddr", paddr, 32'h0);
        rst_n  = 1'b1;
        pready = 1'b1;
        step();
        chk("t5_rel_rspv",  32'(rsp_valid), 32'h0);
        chk("t5_rel_ready", 32'(req_ready), 32'h1);
        chk("t5_rel_psel",  32'(psel),      32'h0);
        set_req(32'h3000, 1'b1, 32'h0000_0055, 4'h3, 3'h0);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("t5_new_paddr", paddr, 32'h3000);
        step();
        step();
        chk("t5_new_rspv", 32'(rsp_valid), 32'h1);
        chk("t5_new_err",  32'(rsp_err),   32'h0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

`ifdef APB_MST_TIMEOUT_EN
        // ---------------- 6a: timeout, pready never arrives
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h7777_7777;
        set_req(32'h6000, 1'b0, 32'h0, 4'h0, 3'h0);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();                                   // ACCESS cycle 1
        for (int i = 0; i < 3; i++) begin
            step();                               // ACCESS cycles 2..4
            chk("t6a_wait_penable", 32'(penable), 32'h1);
        end
        step();
        chk("t6a_rspv",  32'(rsp_valid), 32'h1);
        chk("t6a_err",   32'(rsp_err),   32'h1);
        chk("t6a_rdata", rsp_rdata,      32'h0);
        chk("t6a_psel",  32'(psel),      32'h0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // ---------------- 6b: pready in the 4th ACCESS cycle wins
        prdata = 32'hCAFE_0001;
        set_req(32'h6004, 1'b0, 32'h0, 4'h0, 3'h0);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();                                   // ACCESS cycle 1
        step();
        step();
        step();                                   // now in ACCESS cycle 4
        chk("t6b_c4_penable", 32'(penable), 32'h1);
        pready = 1'b1;
        step();
        pready = 1'b0;
        chk("t6b_rspv",  32'(rsp_valid), 32'h1);
        chk("t6b_err",   32'(rsp_err),   32'h0);
        chk("t6b_rdata", rsp_rdata,      32'hCAFE_0001);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
